// File: rtl/rx_os_counter_if.sv
// Ordered-set qualifier bundle: received-OS strobe and fields in, run count/done/captured fields out.
// Master is the LTSSM/decoder side; slave is the rx_os_counter.
interface rx_os_counter_if #(
  parameter int Width = 5
);
  logic             Enable;
  logic             Start;
  logic [1:0]       ExpectedType;
  logic             OsValid;
  logic [1:0]       OsType;
  logic [7:0]       OsLinkNum;
  logic [7:0]       OsLaneNum;
  logic [Width-1:0] Count;
  logic             Done;
  logic [7:0]       LinkNumOut;
  logic [7:0]       LaneNumOut;

  modport master (
    output Enable, Start, ExpectedType, OsValid, OsType, OsLinkNum, OsLaneNum,
    input  Count, Done, LinkNumOut, LaneNumOut
  );

  modport slave (
    input  Enable, Start, ExpectedType, OsValid, OsType, OsLinkNum, OsLaneNum,
    output Count, Done, LinkNumOut, LaneNumOut
  );
endinterface

// File: rtl/rx_os_counter.sv
// Counts consecutive TS1/TS2 ordered sets; Done one cycle after the REQ_COUNT-th, Start clears.
// Link/Lane consistency is enforced only when RX_OS_FIELD_CHECK_EN is defined.
module rx_os_counter #(
  parameter int Width     = 5,
  parameter int REQ_COUNT = 8
) (
  input  logic            Pclk,
  input  logic            Reset,
  rx_os_counter_if.slave  os
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam logic [Width-1:0] REQ   = Width'(REQ_COUNT);
  localparam logic [1:0]       OS_SKP = 2'b11;

  state_e           state_q, state_d;
  logic [Width-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [7:0]       link_q, link_d;
  logic [7:0]       lane_q, lane_d;

  logic             os_seen;
  logic             qual;
  logic             field_match;
  logic             break_run;
  logic [Width-1:0] count_inc;

  assign os_seen   = os.Enable && os.OsValid;
  assign qual      = os_seen && (os.OsType == os.ExpectedType);
  assign break_run = os_seen && !qual && (os.OsType != OS_SKP);
  assign count_inc = count_q + 1'b1;

`ifdef RX_OS_FIELD_CHECK_EN
  assign field_match = (os.OsLinkNum == link_q) && (os.OsLaneNum == lane_q);
`else
  assign field_match = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    link_d  = link_q;
    lane_d  = lane_q;
    if (os.Start) begin
      state_d = IDLE;
      count_d = '0;
      done_d  = 1'b0;
      link_d  = '0;
      lane_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (qual) begin
            link_d  = os.OsLinkNum;
            lane_d  = os.OsLaneNum;
            count_d = Width'(1);
            if (REQ == Width'(1)) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = COUNTING;
            end
          end
        end
        COUNTING: begin
          if (qual && field_match) begin
            count_d = count_inc;
            if (count_inc == REQ) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else if (qual) begin
            // Inconsistent link/lane: this OS becomes the first of a new run
            link_d  = os.OsLinkNum;
            lane_d  = os.OsLaneNum;
            count_d = Width'(1);
          end else if (break_run) begin
            state_d = IDLE;
            count_d = '0;
            link_d  = '0;
            lane_d  = '0;
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          done_d  = 1'b0;
          link_d  = '0;
          lane_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      link_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      link_q  <= link_d;
      lane_q  <= lane_d;
    end
  end

  assign os.Count      = count_q;
  assign os.Done       = done_q;
  assign os.LinkNumOut = link_q;
  assign os.LaneNumOut = lane_q;
endmodule

// File: tb/tb_rx_os_counter.sv
// Directed bench for rx_os_counter with a run-length model checked every cycle.
module tb_rx_os_counter;
  localparam int W   = 5;
  localparam int REQ = 8;

  logic Pclk  = 1'b0;
  logic Reset = 1'b0;

  rx_os_counter_if #(.Width(W)) os_if ();

  rx_os_counter #(.Width(W), .REQ_COUNT(REQ)) dut (
    .Pclk  (Pclk),
    .Reset (Reset),
    .os    (os_if)
  );

  always #5 Pclk = ~Pclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is just a length plus the fields of its first OS; done latches at REQ.
  int         m_count = 0;
  logic       m_done  = 1'b0;
  logic [7:0] m_link  = 8'h00;
  logic [7:0] m_lane  = 8'h00;

  always @(posedge Pclk or negedge Reset) begin
    if (!Reset || os_if.Start) begin
      m_count = 0; m_done = 1'b0; m_link = 8'h00; m_lane = 8'h00;
    end else if (os_if.Enable && os_if.OsValid && !m_done) begin
      if (os_if.OsType == os_if.ExpectedType) begin
        bit restart;
        restart = (m_count == 0);
`ifdef RX_OS_FIELD_CHECK_EN
        if (os_if.OsLinkNum != m_link || os_if.OsLaneNum != m_lane) restart = 1'b1;
`endif
        if (restart) begin
          m_count = 1; m_link = os_if.OsLinkNum; m_lane = os_if.OsLaneNum;
        end else begin
          m_count = m_count + 1;
        end
        if (m_count == REQ) m_done = 1'b1;
      end else if (os_if.OsType != 2'b11) begin
        m_count = 0; m_link = 8'h00; m_lane = 8'h00;
      end
    end
  end

  always @(negedge Pclk) begin
    if (Reset) begin
      chk("cyc_count", os_if.Count, m_count);
      chk("cyc_done",  os_if.Done,  m_done);
      chk("cyc_link",  os_if.LinkNumOut, m_link);
      chk("cyc_lane",  os_if.LaneNumOut, m_lane);
    end
  end

  task automatic tick();
    @(posedge Pclk); #1;
  endtask

  task automatic os(input logic [1:0] t, input logic [7:0] lk, input logic [7:0] ln);
    os_if.OsValid = 1'b1; os_if.OsType = t; os_if.OsLinkNum = lk; os_if.OsLaneNum = ln;
    tick();
    os_if.OsValid = 1'b0; os_if.OsType = 2'b00;
  endtask

  task automatic ts1(input int n, input logic [7:0] ln);
    for (int i = 0; i < n; i++) os(2'b01, 8'h00, ln);
  endtask

  task automatic do_start();
    os_if.Start = 1'b1; tick(); os_if.Start = 1'b0;
  endtask

  initial begin
    os_if.Enable = 1'b1; os_if.Start = 1'b0; os_if.ExpectedType = 2'b01;
    os_if.OsValid = 1'b0; os_if.OsType = 2'b00; os_if.OsLinkNum = 8'h00; os_if.OsLaneNum = 8'h00;
    #12;
    chk("rst_count", os_if.Count, 0);
    chk("rst_done",  os_if.Done, 0);
    chk("rst_link",  os_if.LinkNumOut, 0);
    chk("rst_lane",  os_if.LaneNumOut, 0);
    Reset = 1'b1;
    tick();

    // 8 back-to-back TS1, count steps 1..8
    for (int i = 1; i <= 8; i++) begin
      os(2'b01, 8'h00, 8'h03);
      chk("step_count", os_if.Count, i);
      chk("step_done", os_if.Done, (i == 8));
    end
    chk("t1_lane", os_if.LaneNumOut, 8'h03);
    chk("t1_link", os_if.LinkNumOut, 8'h00);
    os(2'b01, 8'h00, 8'h03);
    os(2'b00, 8'h00, 8'h00);
    chk("sat_count", os_if.Count, 8);
    chk("sat_done", os_if.Done, 1);
    do_start();
    chk("start_count", os_if.Count, 0);

    // TS2 breaks a TS1 run
    ts1(5, 8'h03);
    os(2'b10, 8'h00, 8'h03);
    chk("brk_count", os_if.Count, 0);
    chk("brk_done", os_if.Done, 0);
    chk("brk_lane", os_if.LaneNumOut, 0);
    ts1(8, 8'h03);
    chk("brk_redone", os_if.Done, 1);
    do_start();

    // SKP does not break a run
    ts1(2, 8'h03);
    os(2'b11, 8'h00, 8'h00);
    chk("skp1_count", os_if.Count, 2);
    ts1(4, 8'h03);
    os(2'b11, 8'h00, 8'h00);
    chk("skp2_count", os_if.Count, 6);
    ts1(2, 8'h03);
    chk("skp_done", os_if.Done, 1);
    do_start();

    // Lane change mid-run
    ts1(4, 8'h03);
    os(2'b01, 8'h00, 8'h05);
`ifdef RX_OS_FIELD_CHECK_EN
    chk("lane_count", os_if.Count, 1);
    chk("lane_out", os_if.LaneNumOut, 8'h05);
`else
    chk("lane_count", os_if.Count, 5);
    chk("lane_out", os_if.LaneNumOut, 8'h03);
`endif
    do_start();

    // Start coincident with the 8th TS1, then held high with traffic
    ts1(7, 8'h03);
    os_if.Start = 1'b1;
    os(2'b01, 8'h00, 8'h03);
    chk("stcol_count", os_if.Count, 0);
    chk("stcol_done", os_if.Done, 0);
    os(2'b01, 8'h00, 8'h03);
    os(2'b01, 8'h00, 8'h03);
    chk("sthold_count", os_if.Count, 0);
    os_if.Start = 1'b0;

    // Asynchronous reset mid-cycle at count 3
    ts1(3, 8'h03);
    chk("pre_rst_count", os_if.Count, 3);
    #1 Reset = 1'b0;
    #1;
    chk("arst_count", os_if.Count, 0);
    chk("arst_lane", os_if.LaneNumOut, 0);
    #1 Reset = 1'b1;
    tick();

    // Enable low freezes state and drops pulses
    ts1(2, 8'h03);
    os_if.Enable = 1'b0;
    ts1(3, 8'h03);
    os(2'b10, 8'h00, 8'h03);
    chk("en_count", os_if.Count, 2);
    os_if.Enable = 1'b1;
    ts1(6, 8'h03);
    chk("en_done", os_if.Done, 1);
    do_start();

    // TS2 qualification with non-zero link, TS1 breaks it
    os_if.ExpectedType = 2'b10;
    os(2'b10, 8'h2A, 8'h01);
    os(2'b10, 8'h2A, 8'h01);
    chk("ts2_link", os_if.LinkNumOut, 8'h2A);
    chk("ts2_count", os_if.Count, 2);
    os(2'b01, 8'h2A, 8'h01);
    chk("ts2_brk", os_if.Count, 0);
    for (int i = 0; i < 8; i++) os(2'b10, 8'h2A, 8'h01);
    chk("ts2_done", os_if.Done, 1);
    chk("ts2_link2", os_if.LinkNumOut, 8'h2A);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
